// File: rtl/ddr_rd_frame_fetch_pkg.sv
// Shared DDR read-path parameters and the frame fetch state type.
// Pulled in by the frame fetcher and its word unpacker.
package ddr_rd_frame_fetch_pkg;

    localparam int CTRL_ADDR_WIDTH   = 28;
    localparam int MEM_DQ_WIDTH      = 32;
    localparam int WORD_WIDTH        = MEM_DQ_WIDTH * 8;
    localparam int PIX_WIDTH         = 16;
    localparam int PIX_PER_WORD      = 16;
    localparam int PIX_CNT_WIDTH     = $clog2(PIX_PER_WORD + 1);
    localparam int FRAME_WORDS_WIDTH = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } fetch_state_e;

endpackage

// File: rtl/ddr_rd_frame_fetch_word_unpack.sv
// Splits one 256-bit DDR word into sixteen RGB565 pixels, LSB pixel first,
// presented on a valid/ready stream.
module ddr_word_unpack
    import ddr_rd_frame_fetch_pkg::*;
(
    input  logic                  clk_100M,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  pixReady_i,
    output logic [PIX_WIDTH-1:0]  pixData_o,
    output logic                  pixValid_o,
    output logic                  wordDone_o
);

    logic [WORD_WIDTH-1:0]    shiftReg_q;
    logic [PIX_CNT_WIDTH-1:0] pixCnt_q;
    logic                     pixValid_q;
    logic                     handshake;

    assign handshake  = pixValid_q & pixReady_i;
    assign wordDone_o = handshake && (pixCnt_q == PIX_CNT_WIDTH'(1));
    assign pixData_o  = shiftReg_q[PIX_WIDTH-1:0];
    assign pixValid_o = pixValid_q;

    // The low pixel of the shift register is the one on offer, so the data
    // holds by construction while the consumer stalls.
    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            shiftReg_q <= '0;
            pixCnt_q   <= '0;
            pixValid_q <= 1'b0;
        end else if (load_i) begin
            shiftReg_q <= word_i;
            pixCnt_q   <= PIX_CNT_WIDTH'(PIX_PER_WORD);
            pixValid_q <= 1'b1;
        end else if (handshake) begin
            shiftReg_q <= shiftReg_q >> PIX_WIDTH;
            pixCnt_q   <= pixCnt_q - PIX_CNT_WIDTH'(1);
            if (pixCnt_q == PIX_CNT_WIDTH'(1)) begin
                pixValid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ddr_rd_frame_fetch.sv
// Fetches a frame from DDR one single-beat word at a time and streams it out
// as RGB565 pixels; aborts a word read that never returns data.
module ddr_rd_frame_fetch
    import ddr_rd_frame_fetch_pkg::*;
#(
    parameter int ADDR_STEP = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                         clk_100M,
    input  logic                         rstn,
    input  logic                         init_done,
    input  logic                         frame_start,
    input  logic [CTRL_ADDR_WIDTH-1:0]   base_addr,
    input  logic [FRAME_WORDS_WIDTH-1:0] frame_words,
    output logic                         rd_req,
    output logic [CTRL_ADDR_WIDTH-1:0]   rd_addr,
    output logic [3:0]                   arlen,
    input  logic                         rd_busy,
    input  logic [WORD_WIDTH-1:0]        rd_data,
    input  logic                         rdata_valid,
    output logic [PIX_WIDTH-1:0]         pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         frame_busy,
    output logic                         frame_done,
    output logic                         timeout_err
);

    localparam int TMO_WIDTH = $clog2(TIMEOUT + 2);
    localparam logic [TMO_WIDTH-1:0]       TMO_LIMIT = TMO_WIDTH'(TIMEOUT);
    localparam logic [CTRL_ADDR_WIDTH-1:0] STEP      = CTRL_ADDR_WIDTH'(ADDR_STEP);

    fetch_state_e                 state_q;
    logic [CTRL_ADDR_WIDTH-1:0]   curAddr_q;
    logic [FRAME_WORDS_WIDTH-1:0] frameWords_q;
    logic [FRAME_WORDS_WIDTH-1:0] wordCnt_q;
    logic [TMO_WIDTH-1:0]         tmoCnt_q;
    logic                         rdReq_q;
    logic [CTRL_ADDR_WIDTH-1:0]   rdAddr_q;
    logic                         frameBusy_q;
    logic                         frameDone_q;
    logic                         timeoutErr_q;
    logic                         rdValidPrev_q;

    logic                         startOk;
    logic                         validRise;
    logic                         unpackLoad;
    logic                         wordDone;
    logic [CTRL_ADDR_WIDTH-1:0]   nextAddr;
    logic [FRAME_WORDS_WIDTH-1:0] wordCntInc;

    assign startOk    = frame_start && init_done && (frame_words != '0);
    assign validRise  = rdata_valid && !rdValidPrev_q;
    assign unpackLoad = (state_q == ST_WAIT) && validRise;
    assign nextAddr   = curAddr_q + STEP;
    assign wordCntInc = wordCnt_q + FRAME_WORDS_WIDTH'(1);

    assign rd_req      = rdReq_q;
    assign rd_addr     = rdAddr_q;
    assign arlen       = 4'd0;
    assign frame_busy  = frameBusy_q;
    assign frame_done  = frameDone_q;
    assign timeout_err = timeoutErr_q;

    ddr_word_unpack u_unpack (
        .clk_100M   (clk_100M),
        .rstn       (rstn),
        .load_i     (unpackLoad),
        .word_i     (rd_data),
        .pixReady_i (pix_ready),
        .pixData_o  (pix_data),
        .pixValid_o (pix_valid),
        .wordDone_o (wordDone)
    );

    // Entering REQ issues the request straight away when the controller is
    // free, which gives the one-cycle start-to-request latency.
    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            curAddr_q     <= '0;
            frameWords_q  <= '0;
            wordCnt_q     <= '0;
            tmoCnt_q      <= '0;
            rdReq_q       <= 1'b0;
            rdAddr_q      <= '0;
            frameBusy_q   <= 1'b0;
            frameDone_q   <= 1'b0;
            timeoutErr_q  <= 1'b0;
            rdValidPrev_q <= 1'b0;
        end else begin
            rdValidPrev_q <= rdata_valid;
            frameDone_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (startOk) begin
                        curAddr_q    <= base_addr;
                        frameWords_q <= frame_words;
                        wordCnt_q    <= '0;
                        timeoutErr_q <= 1'b0;
                        frameBusy_q  <= 1'b1;
                        rdAddr_q     <= base_addr;
                        rdReq_q      <= !rd_busy;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rdReq_q) begin
                        rdReq_q  <= 1'b0;
                        tmoCnt_q <= '0;
                        state_q  <= ST_WAIT;
                    end else if (!rd_busy) begin
                        rdReq_q  <= 1'b1;
                        rdAddr_q <= curAddr_q;
                    end
                end
                // Only a fresh rising edge means new data; a level left high
                // from the previous word must not be mistaken for a reply.
                ST_WAIT: begin
                    if (validRise) begin
                        state_q <= ST_OUT;
                    end else if (tmoCnt_q > TMO_LIMIT) begin
                        timeoutErr_q <= 1'b1;
                        frameBusy_q  <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + TMO_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    if (wordDone) begin
                        wordCnt_q <= wordCntInc;
                        if (wordCntInc == frameWords_q) begin
                            frameDone_q <= 1'b1;
                            frameBusy_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            curAddr_q <= nextAddr;
                            rdAddr_q  <= nextAddr;
                            rdReq_q   <= !rd_busy;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
